// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C register target: FSM states, ACK/NACK levels
// and the default 7-bit device address.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK
   } state_t;

   localparam logic       ACK              = 1'b0;
   localparam logic       NACK             = 1'b1;
   localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h53;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser plus history flop for SCL/SDA, with edge and
// START/STOP detection on the synchronised lines.
module i2c_line_sync (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic sda_s
);

   // [0],[1] synchronise, [2] holds the previous synchronised level.
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_in};
         sda_q <= {sda_q[1:0], sda_in};
      end
   end

   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
   assign sda_s    = sda_q[1];

endmodule

// File: rtl/i2c_target.sv
// I2C register target: a write loads the register pointer then streams bytes
// out on reg_we; a read streams reg_rdata with pointer auto-increment.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   logic       scl_rise, scl_fall, start, stop, sda_s;
   state_t     state, next_state;
   logic [3:0] bit_cnt, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [6:0] tx_q, tx_d;
   logic [7:0] reg_addr_d, reg_wdata_d;
   logic       sda_oe_d, reg_we_d, busy_d;
   logic [7:0] rx_byte;
   logic       last_bit;

   i2c_line_sync u_line_sync (
      .clk      (clk),
      .reset    (reset),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop),
      .sda_s    (sda_s)
   );

   assign rx_byte  = {shift_q, sda_s};
   assign last_bit = (bit_cnt == 4'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path infers a latch.
      next_state = state;
      if (start) begin
         next_state = ADDR;
      end else if (stop) begin
         next_state = IDLE;
      end else begin
         case (state)
            ADDR:      if (scl_rise && last_bit)
                          next_state = (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
            PTR:       if (scl_rise && last_bit) next_state = PTR_ACK;
            WDATA:     if (scl_rise && last_bit) next_state = WDATA_ACK;
            ADDR_ACK:  if (scl_fall && sda_oe) next_state = shift_q[0] ? RDATA : PTR;
            PTR_ACK,
            WDATA_ACK: if (scl_fall && sda_oe) next_state = WDATA;
            RDATA:     if (scl_fall && bit_cnt == 4'd8) next_state = RACK;
            RACK:      if (scl_rise && sda_s == NACK) next_state = IDLE;
                       else if (scl_fall)             next_state = RDATA;
            default:   next_state = state;
         endcase
      end
   end

   always_comb begin
      sda_oe_d    = sda_oe;
      bit_cnt_d   = bit_cnt;
      shift_d     = shift_q;
      tx_d        = tx_q;
      reg_addr_d  = reg_addr;
      reg_wdata_d = reg_wdata;
      reg_we_d    = 1'b0;
      busy_d      = busy;
      if (start) begin
         sda_oe_d  = 1'b0;
         bit_cnt_d = '0;
      end else if (stop) begin
         sda_oe_d  = 1'b0;
         bit_cnt_d = '0;
         busy_d    = 1'b0;
      end else begin
         case (state)
            ADDR, PTR, WDATA: if (scl_rise) begin
               shift_d   = rx_byte[6:0];
               bit_cnt_d = bit_cnt + 4'd1;
               if (last_bit) begin
                  bit_cnt_d = '0;
                  if (state == ADDR)     busy_d = (rx_byte[7:1] == DEV_ADDR);
                  else if (state == PTR) reg_addr_d = rx_byte;
                  else begin
                     reg_wdata_d = rx_byte;
                     reg_we_d    = 1'b1;
                  end
               end
            end
            // First fall drives the ACK, the second one releases it.
            ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
               sda_oe_d = ~sda_oe;
               if (sda_oe) begin
                  if (state == WDATA_ACK) reg_addr_d = reg_addr + 8'd1;
                  if (state == ADDR_ACK && shift_q[0]) begin
                     sda_oe_d = ~reg_rdata[7];
                     tx_d     = reg_rdata[6:0];
                  end
               end
            end
            RDATA: if (scl_rise) begin
               bit_cnt_d = bit_cnt + 4'd1;
            end else if (scl_fall) begin
               if (bit_cnt == 4'd8) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
               end else begin
                  sda_oe_d = ~tx_q[6];
                  tx_d     = {tx_q[5:0], 1'b0};
               end
            end
            RACK: if (scl_rise) begin
               if (sda_s == ACK) reg_addr_d = reg_addr + 8'd1;
               else              busy_d     = 1'b0;
            end else if (scl_fall) begin
               sda_oe_d = ~reg_rdata[7];
               tx_d     = reg_rdata[6:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sda_oe    <= 1'b0;
         bit_cnt   <= '0;
         shift_q   <= '0;
         tx_q      <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sda_oe    <= sda_oe_d;
         bit_cnt   <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         reg_addr  <= reg_addr_d;
         reg_wdata <= reg_wdata_d;
         reg_we    <= reg_we_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master driving i2c_target, with scoreboards for ACKs,
// read bytes and register write strobes.
module tb_i2c_target;
   import i2c_pkg::*;

   localparam int CLK_HALF = 10;
   localparam int Q        = 200;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       scl   = 1'b1;
   logic       msda  = 1'b1;
   wire        sda_line;
   logic       sda_oe, reg_we, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic [7:0] mem [256];

   wr_t        wr_q[$];
   logic [7:0] rd_q[$];
   logic       ack_q[$];
   wr_t        exp_wr;
   logic       oe_seen = 1'b0;
   int         errors  = 0;
   int         checks  = 0;

   assign sda_line  = msda & ~sda_oe;
   assign reg_rdata = mem[reg_addr];

   always #CLK_HALF clk = ~clk;

   i2c_target #(.DEV_ADDR(7'h53)) dut (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   // Write-strobe scoreboard: every reg_we must match the oldest expected write.
   always @(negedge clk) begin
      if (sda_oe === 1'b1) oe_seen = 1'b1;
      if (reg_we === 1'b1) begin
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr=%02h data=%02h, required no write", reg_addr, reg_wdata);
         end else begin
            exp_wr = wr_q.pop_front();
            if (reg_addr !== exp_wr.addr || reg_wdata !== exp_wr.data) begin
               errors++;
               $display("FAIL write_data: got addr=%02h data=%02h, required addr=%02h data=%02h",
                        reg_addr, reg_wdata, exp_wr.addr, exp_wr.data);
            end
         end
      end
   end

   task automatic wbit(input logic b);
      msda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
   endtask

   task automatic rbit(output logic b);
      msda = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
   endtask

   task automatic bus_start;
      msda = 1'b1; #Q; scl = 1'b1; #Q; msda = 1'b0; #Q; scl = 1'b0; #Q;
   endtask

   task automatic bus_stop;
      msda = 1'b0; #Q; scl = 1'b1; #Q; msda = 1'b1; #Q;
   endtask

   task automatic write_byte(input logic [7:0] b, input logic exp_ack);
      logic got, want;
      ack_q.push_back(exp_ack);
      for (int i = 7; i >= 0; i--) wbit(b[i]);
      rbit(got);
      want = ack_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL ack after %02h: got %b, required %b", b, got, want);
      end
   endtask

   task automatic read_byte;
      logic [7:0] got;
      logic [7:0] want;
      logic       x;
      for (int i = 7; i >= 0; i--) begin
         rbit(x);
         got[i] = x;
      end
      want = rd_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL read_byte: got %02h, required %02h", got, want);
      end
   endtask

   task automatic test_reset;
      repeat (4) @(negedge clk);
      checks++;
      if (sda_oe !== 1'b0 || reg_addr !== 8'h00 || reg_wdata !== 8'h00 || reg_we !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got oe=%b addr=%02h wdata=%02h we=%b busy=%b, required all 0",
                  sda_oe, reg_addr, reg_wdata, reg_we, busy);
      end
      checks++;
      if (dut.state !== IDLE || dut.bit_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: got state=%0d cnt=%0d, required 0 0", dut.state, dut.bit_cnt);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write;
      bus_start;
      write_byte(8'hA6, ACK);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_on_match: got %b, required 1", busy); end
      write_byte(8'h31, ACK);
      checks++;
      if (reg_addr !== 8'h31) begin errors++; $display("FAIL ptr_load: got %02h, required 31", reg_addr); end
      wr_q.push_back('{addr: 8'h31, data: 8'h0B});
      write_byte(8'h0B, ACK);
      bus_stop;
      checks++;
      if (reg_addr !== 8'h32 || busy !== 1'b0) begin
         errors++;
         $display("FAIL write_end: got addr=%02h busy=%b, required 32 0", reg_addr, busy);
      end
      checks++;
      if (wr_q.size() != 0) begin errors++; $display("FAIL write_missing: got %0d pending, required 0", wr_q.size()); end
   endtask

   task automatic test_read;
      bus_start;
      write_byte(8'hA6, ACK);
      write_byte(8'h32, ACK);
      bus_start;
      write_byte(8'hA7, ACK);
      checks++;
      if (reg_addr !== 8'h32) begin errors++; $display("FAIL rstart_keeps_ptr: got %02h, required 32", reg_addr); end
      rd_q.push_back(8'hA5);
      read_byte();
      wbit(ACK);
      rd_q.push_back(8'h5A);
      read_byte();
      checks++;
      if (busy !== 1'b1 || sda_oe !== 1'b0) begin
         errors++;
         $display("FAIL before_nack: got busy=%b oe=%b, required 1 0", busy, sda_oe);
      end
      wbit(NACK);
      checks++;
      if (busy !== 1'b0 || reg_addr !== 8'h33 || dut.state !== IDLE) begin
         errors++;
         $display("FAIL after_nack: got busy=%b addr=%02h state=%0d, required 0 33 IDLE", busy, reg_addr, dut.state);
      end
      bus_stop;
   endtask

   task automatic test_mismatch;
      oe_seen = 1'b0;
      bus_start;
      write_byte(8'h3A, NACK);
      checks++;
      if (busy !== 1'b0 || dut.state !== IDLE) begin
         errors++;
         $display("FAIL mismatch_idle: got busy=%b state=%0d, required 0 IDLE", busy, dut.state);
      end
      write_byte(8'hA6, NACK);
      checks++;
      if (oe_seen !== 1'b0) begin errors++; $display("FAIL mismatch_oe: got driven=%b, required 0", oe_seen); end
      bus_stop;
   endtask

   task automatic test_wrap;
      bus_start;
      write_byte(8'hA6, ACK);
      write_byte(8'hFF, ACK);
      wr_q.push_back('{addr: 8'hFF, data: 8'h11});
      wr_q.push_back('{addr: 8'h00, data: 8'h22});
      write_byte(8'h11, ACK);
      write_byte(8'h22, ACK);
      bus_stop;
      checks++;
      if (reg_addr !== 8'h01 || wr_q.size() != 0) begin
         errors++;
         $display("FAIL wrap: got addr=%02h pending=%0d, required 01 0", reg_addr, wr_q.size());
      end
   endtask

   task automatic test_stop_mid;
      bus_start;
      write_byte(8'hA6, ACK);
      write_byte(8'h10, ACK);
      wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
      bus_stop;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dut.state !== IDLE || reg_addr !== 8'h10 || sda_oe !== 1'b0) begin
         errors++;
         $display("FAIL stop_mid: got busy=%b state=%0d addr=%02h oe=%b, required 0 IDLE 10 0",
                  busy, dut.state, reg_addr, sda_oe);
      end
   endtask

   task automatic test_reset_read;
      logic x;
      bus_start;
      write_byte(8'hA6, ACK);
      write_byte(8'h40, ACK);
      bus_start;
      write_byte(8'hA7, ACK);
      checks++;
      if (sda_oe !== 1'b1) begin errors++; $display("FAIL read_drive0: got oe=%b, required 1", sda_oe); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (sda_oe !== 1'b0 || dut.state !== IDLE || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_read: got oe=%b state=%0d busy=%b, required 0 IDLE 0", sda_oe, dut.state, busy);
      end
      repeat (4) @(negedge clk);
      reset = 1'b0;
      oe_seen = 1'b0;
      for (int i = 7; i >= 0; i--) wbit(8'hA6 >> i);
      rbit(x);
      checks++;
      if (x !== NACK || oe_seen !== 1'b0) begin
         errors++;
         $display("FAIL ignore_until_start: got ack=%b driven=%b, required 1 0", x, oe_seen);
      end
      bus_stop;
   endtask

   task automatic test_back_to_back;
      bus_start;
      write_byte(8'hA6, ACK);
      write_byte(8'h07, ACK);
      wr_q.push_back('{addr: 8'h07, data: 8'hC3});
      write_byte(8'hC3, ACK);
      bus_start;
      write_byte(8'hA7, ACK);
      rd_q.push_back(mem[8'h08]);
      read_byte();
      wbit(NACK);
      bus_stop;
      checks++;
      if (reg_addr !== 8'h08 || busy !== 1'b0 || wr_q.size() != 0) begin
         errors++;
         $display("FAIL back_to_back: got addr=%02h busy=%b pending=%0d, required 08 0 0", reg_addr, busy, wr_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
      mem[8'h32] = 8'hA5;
      mem[8'h33] = 8'h5A;
      mem[8'h40] = 8'h0F;
      test_reset;
      test_write;
      test_read;
      test_mismatch;
      test_wrap;
      test_stop_mid;
      test_reset_read;
      test_back_to_back;
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h53, the 7-bit target address answered (accelerometer address).
REQ-002 SHALL have port clk, input, 1, the system clock (50 MHz); the clock SHALL run at least 16x the SCL rate.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port scl_in, input, 1, the raw SCL line (asynchronous).
REQ-005 SHALL have port sda_in, input, 1, the raw SDA line (asynchronous).
REQ-006 SHALL have port sda_oe, output, 1; 1 pulls SDA low, 0 releases it (open-drain, external tristate).
REQ-007 SHALL have port reg_addr, output, 8, the current register pointer.
REQ-008 SHALL have port reg_wdata, output, 8, the last received data byte.
REQ-009 SHALL have port reg_we, output, 1, a one-clk write strobe for reg_wdata to reg_addr.
REQ-010 SHALL have port reg_rdata, input, 8, the register contents at reg_addr; the source is combinational.
REQ-011 SHALL have port busy, output, 1; high from an address match until STOP, mismatch or NACK.

Function
REQ-012 SHALL synchronise scl_in and sda_in through 2 flops plus 1 history flop; a line event SHALL be detected 3 clk after the pin change.
REQ-013 SHALL treat an SDA fall while SCL is high as START, and an SDA rise while SCL is high as STOP.
REQ-014 SHALL sample SDA on each SCL rising edge, MSB first, and SHALL change sda_oe only on SCL falling edges.
REQ-015 SHALL use the states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA and RACK.
REQ-016 IDLE SHALL hold sda_oe=0; a START SHALL go to ADDR with the bit counter at 0.
REQ-017 In ADDR, after 8 bits with addr[7:1]==DEV_ADDR, the block SHALL go to ADDR_ACK; on mismatch it SHALL go to IDLE without ACK.
REQ-018 An ACK SHALL assert sda_oe at the SCL fall after bit 8 and release it at the next SCL fall.
REQ-019 After ADDR_ACK with R/W=0, the block SHALL go to PTR; after the first byte, reg_addr SHALL be loaded from that byte, then ACK, then go to WDATA.
REQ-020 In WDATA, on the 8th rising edge, reg_wdata SHALL be set and reg_we pulsed for 1 clk; then ACK, then reg_addr SHALL increment at the ACK release.
REQ-021 After ADDR_ACK with R/W=1, reg_rdata SHALL be latched at the SCL fall ending the ACK; the block SHALL drive sda_oe=~bit for 8 bits, then release for the master ACK.
REQ-022 In RACK, the block SHALL sample SDA on the rising edge: 0 SHALL increment reg_addr and return to RDATA with a fresh latch; 1 (NACK) SHALL go to IDLE with busy=0.
REQ-023 reg_addr SHALL increment modulo 256 (8'hFF -> 8'h00).
REQ-024 A repeated START in any state SHALL go to ADDR, release sda_oe and keep reg_addr.
REQ-025 A STOP in any state SHALL go to IDLE with sda_oe=0 and busy=0; a STOP mid-byte SHALL discard the partial byte with no reg_we.
REQ-026 If a START and an SCL edge are detected in the same clk, the START SHALL take priority.

Reset
REQ-027 While reset is asserted: state=IDLE, sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, bit counter=0, sync flops=1 (idle bus).
REQ-028 Reset mid-transfer SHALL release SDA immediately (asynchronously) and ignore the bus until the next START.

Structure
REQ-029 Package i2c_pkg SHALL hold the state encoding, the ACK=0/NACK=1 constants and the default address 7'h53.
REQ-030 The synchroniser/edge detector SHALL be sub-module i2c_line_sync, with outputs scl_rise, scl_fall, start, stop and sda_s.

Verification
REQ-031 Write 0x53+W, 0x31, 0x0B, then STOP -> three ACKs; reg_we pulses once with reg_addr=0x31 and reg_wdata=0x0B; reg_addr ends at 0x32.
REQ-032 Pointer 0x32, repeated START, 0x53+R, rdata 0xA5 then 0x5A, master ACK then NACK -> SDA bits 10100101 then 01011010; busy falls after the NACK.
REQ-033 Address 0x1D+W -> no ACK (sda_oe stays 0), busy=0, no reg_we until the next START.
REQ-034 Pointer 0xFF, write 2 data bytes -> reg_we at 0xFF then 0x00.
REQ-035 STOP after 4 data bits; and separately reset asserted during a read while driving 0 -> no reg_we, sda_oe=0 at once, state IDLE.
